// File: rtl/nabp_line_buffer.sv
// nabp_line_buffer: shift-register line buffer feeding the PE array.
// Each enabled cycle one filtered sample enters entry 0 and everything moves one
// entry deeper. Evenly spaced taps present entries k*TAP_STRIDE to the PEs.
// Optional build macro: NABP_LB_TAP_MASK_EN forces a tap lane to zero while its
// entry is not valid. Without it the raw data register is presented.
//
// Handshake: there is no valid/ready pair on the input side. lb_shift_en qualifies
// fm_val in the same cycle, lb_clear wins over lb_shift_en, and there is no
// back-pressure. lb_ready only reports that the last PE tap holds real data.
module nabp_line_buffer #(
  parameter int DATA_WIDTH = 16,
  parameter int LENGTH     = 256,
  parameter int NUM_TAPS   = 4,
  parameter int TAP_STRIDE = 64,
  parameter int CNT_WIDTH  = 9
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           lb_clear,
  input  logic                           lb_shift_en,
  input  logic [DATA_WIDTH-1:0]          fm_val,
  output logic [NUM_TAPS*DATA_WIDTH-1:0] pe_taps,
  output logic [NUM_TAPS-1:0]            pe_taps_valid,
  output logic                           lb_ready,
  output logic                           lb_full,
  output logic [CNT_WIDTH-1:0]           lb_occupancy,
  output logic [1:0]                     lb_state
);

  localparam int LAST_TAP = (NUM_TAPS - 1) * TAP_STRIDE;
  localparam logic [CNT_WIDTH-1:0] FULL_CNT = CNT_WIDTH'(LENGTH);
  localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(LAST_TAP);

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_FILLING = 2'd1,
    ST_READY   = 2'd2,
    ST_FULL    = 2'd3
  } state_t;

  logic [DATA_WIDTH-1:0] data_q [LENGTH];
  logic [LENGTH-1:0]     valid_q;
  logic [CNT_WIDTH-1:0]  occ_q;
  logic [CNT_WIDTH-1:0]  occ_next;
  state_t                state_q;
  state_t                state_next;
  logic                  do_shift;

  // A clear in the same cycle discards the shift and its sample.
  assign do_shift = lb_shift_en && !lb_clear;

  // Data shift chain; contents are kept across a clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < LENGTH; i++) data_q[i] <= '0;
    end else if (do_shift) begin
      data_q[0] <= fm_val;
      for (int i = 1; i < LENGTH; i++) data_q[i] <= data_q[i-1];
    end
  end

  // Validity chain: a clear empties it, a shift pushes a 1 in at entry 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= '0;
    end else if (lb_clear) begin
      valid_q <= '0;
    end else if (lb_shift_en) begin
      valid_q <= {valid_q[LENGTH-2:0], 1'b1};
    end
  end

  // Next occupancy: cleared on lb_clear, saturating increment on shift.
  always_comb begin
    occ_next = occ_q;
    if (lb_clear) begin
      occ_next = '0;
    end else if (lb_shift_en && (occ_q != FULL_CNT)) begin
      occ_next = occ_q + 1'b1;
    end
  end

  // Occupancy and control state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      occ_q   <= '0;
      state_q <= ST_EMPTY;
    end else begin
      occ_q   <= occ_next;
      state_q <= state_next;
    end
  end

  // Control state follows the occupancy it will have after this edge.
  always_comb begin
    state_next = state_q;
    if (occ_next == '0) begin
      state_next = ST_EMPTY;
    end else if (occ_next == FULL_CNT) begin
      state_next = ST_FULL;
    end else if (occ_next > LAST_CNT) begin
      state_next = ST_READY;
    end else begin
      state_next = ST_FILLING;
    end
  end

  // Tap lanes, taken straight from storage.
  for (genvar k = 0; k < NUM_TAPS; k++) begin : g_tap
    assign pe_taps_valid[k] = valid_q[k*TAP_STRIDE];
`ifdef NABP_LB_TAP_MASK_EN
    assign pe_taps[k*DATA_WIDTH +: DATA_WIDTH] =
      valid_q[k*TAP_STRIDE] ? data_q[k*TAP_STRIDE] : '0;
`else
    assign pe_taps[k*DATA_WIDTH +: DATA_WIDTH] = data_q[k*TAP_STRIDE];
`endif
  end

  assign lb_ready     = valid_q[LAST_TAP];
  assign lb_full      = (occ_q == FULL_CNT);
  assign lb_occupancy = occ_q;
  assign lb_state     = state_q;

endmodule
